// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: memControl codes, FSM states and size helpers.
package lsu_pkg;

    localparam logic [2:0] MEM_BYTE       = 3'd0;
    localparam logic [2:0] MEM_HALFWORD   = 3'd1;
    localparam logic [2:0] MEM_WORD       = 3'd2;
    localparam logic [2:0] MEM_DWORD      = 3'd3;
    localparam logic [2:0] MEM_BYTE_U     = 3'd4;
    localparam logic [2:0] MEM_HALFWORD_U = 3'd5;
    localparam logic [2:0] MEM_WORD_U     = 3'd6;
    localparam logic [2:0] MEM_INVALID    = 3'd7;

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} lsu_state_t;

    function automatic logic [3:0] size_bytes(input logic [2:0] ctrl);
        unique case (ctrl)
            MEM_BYTE, MEM_BYTE_U:         size_bytes = 4'd1;
            MEM_HALFWORD, MEM_HALFWORD_U: size_bytes = 4'd2;
            MEM_WORD, MEM_WORD_U:         size_bytes = 4'd4;
            default:                      size_bytes = 4'd8;
        endcase
    endfunction

    function automatic logic is_unsigned(input logic [2:0] ctrl);
        is_unsigned = (ctrl == MEM_BYTE_U) || (ctrl == MEM_HALFWORD_U) || (ctrl == MEM_WORD_U);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment: store strobes/data placed across two dwords, load data merged and extended.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]   ctrl_i,
    input  logic [2:0]   off_i,
    input  logic [63:0]  wdata_i,
    input  logic [63:0]  lo_i,
    input  logic [63:0]  hi_i,
    output logic [15:0]  s16_o,
    output logic [127:0] d128_o,
    output logic [63:0]  rdata_o
);

    logic [63:0] low;
    logic [63:0] wmask;
    logic [15:0] s_base;
    logic        uns;

    always_comb begin
        uns = is_unsigned(ctrl_i);
        low = 64'({hi_i, lo_i} >> {off_i, 3'b000});
        case (ctrl_i[1:0])
            2'd0: begin
                s_base  = 16'h0001;
                wmask   = 64'h0000_0000_0000_00ff;
                rdata_o = uns ? {56'b0, low[7:0]} : {{56{low[7]}}, low[7:0]};
            end
            2'd1: begin
                s_base  = 16'h0003;
                wmask   = 64'h0000_0000_0000_ffff;
                rdata_o = uns ? {48'b0, low[15:0]} : {{48{low[15]}}, low[15:0]};
            end
            2'd2: begin
                s_base  = 16'h000f;
                wmask   = 64'h0000_0000_ffff_ffff;
                rdata_o = uns ? {32'b0, low[31:0]} : {{32{low[31]}}, low[31:0]};
            end
            default: begin
                s_base  = 16'h00ff;
                wmask   = '1;
                rdata_o = low;
            end
        endcase
        s16_o  = s_base << off_i;
        d128_o = {64'b0, wdata_i & wmask} << {off_i, 3'b000};
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: splits dword-crossing accesses into LO/HI transactions.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of splitting them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned MEM_DWORDS = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [2:0]       req_ctrl,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_misaligned,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [63:0]      mem_wdata,
    output logic [7:0]       mem_wstrb,
    input  logic             mem_ack,
    input  logic [63:0]      mem_rdata
);

    lsu_state_t       state_q;
    logic             write_q;
    logic [2:0]       ctrl_q;
    logic [2:0]       off_q;
    logic [63:0]      wdata_q;
    logic [63:0]      lo_q;
    logic             mem_req_q, mem_we_q, resp_valid_q, resp_misaligned_q;
    logic [WIDTH-1:0] mem_addr_q, resp_rdata_q;
    logic [63:0]      mem_wdata_q;
    logic [7:0]       mem_wstrb_q;

    logic             idle, split, misaligned;
    logic [2:0]       ctrl_sel, off_sel;
    logic [3:0]       n_sel;
    logic [63:0]      wdata_sel, lo_sel, hi_sel, rdata_ext;
    logic [15:0]      s16;
    logic [127:0]     d128;

    // In IDLE the aligner looks at the incoming request so LO outputs can be registered on accept.
    assign idle      = (state_q == IDLE);
    assign ctrl_sel  = idle ? req_ctrl : ctrl_q;
    assign off_sel   = idle ? req_addr[2:0] : off_q;
    assign wdata_sel = idle ? req_wdata : wdata_q;
    assign lo_sel    = (state_q == LO) ? mem_rdata : lo_q;
    assign hi_sel    = (state_q == HI) ? mem_rdata : 64'b0;
    assign n_sel     = size_bytes(ctrl_sel);
    assign split     = ({1'b0, off_sel} + n_sel) > 4'd8;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = (ctrl_sel != MEM_INVALID) && ((off_sel & (n_sel[2:0] - 3'd1)) != 3'd0);
`else
    assign misaligned = 1'b0;
`endif

    lsu_align u_align (
        .ctrl_i  (ctrl_sel),
        .off_i   (off_sel),
        .wdata_i (wdata_sel),
        .lo_i    (lo_sel),
        .hi_i    (hi_sel),
        .s16_o   (s16),
        .d128_o  (d128),
        .rdata_o (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            write_q           <= 1'b0;
            ctrl_q            <= '0;
            off_q             <= '0;
            wdata_q           <= '0;
            lo_q              <= '0;
            mem_req_q         <= 1'b0;
            mem_we_q          <= 1'b0;
            mem_addr_q        <= '0;
            mem_wdata_q       <= '0;
            mem_wstrb_q       <= '0;
            resp_valid_q      <= 1'b0;
            resp_misaligned_q <= 1'b0;
            resp_rdata_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        ctrl_q  <= req_ctrl;
                        off_q   <= req_addr[2:0];
                        wdata_q <= req_wdata;
                        lo_q    <= '0;
                        if (req_ctrl == MEM_INVALID || misaligned) begin
                            state_q           <= RESP;
                            resp_valid_q      <= 1'b1;
                            resp_misaligned_q <= misaligned;
                            resp_rdata_q      <= '0;
                        end else begin
                            state_q     <= LO;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_write;
                            mem_addr_q  <= {req_addr[WIDTH-1:3], 3'b000};
                            mem_wstrb_q <= req_write ? s16[7:0] : 8'h00;
                            mem_wdata_q <= d128[63:0];
                        end
                    end
                end
                LO: begin
                    if (mem_ack) begin
                        lo_q <= mem_rdata;
                        if (split) begin
                            state_q     <= HI;
                            mem_addr_q  <= mem_addr_q + WIDTH'(8);
                            mem_wstrb_q <= write_q ? s16[15:8] : 8'h00;
                            mem_wdata_q <= d128[127:64];
                        end else begin
                            state_q      <= RESP;
                            mem_req_q    <= 1'b0;
                            mem_we_q     <= 1'b0;
                            mem_wstrb_q  <= '0;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= write_q ? '0 : rdata_ext;
                        end
                    end
                end
                HI: begin
                    if (mem_ack) begin
                        state_q      <= RESP;
                        mem_req_q    <= 1'b0;
                        mem_we_q     <= 1'b0;
                        mem_wstrb_q  <= '0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= write_q ? '0 : rdata_ext;
                    end
                end
                RESP: begin
                    state_q           <= IDLE;
                    resp_valid_q      <= 1'b0;
                    resp_misaligned_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready       = idle;
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_misaligned = resp_misaligned_q;
    assign mem_req         = mem_req_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_wstrb       = mem_wstrb_q;

    mem_in_range_a: assert property (@(posedge clk) disable iff (!rst_n)
        mem_req |-> (mem_addr >> 3) < WIDTH'(MEM_DWORDS));

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a wait-state-capable dword memory responder.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_ctrl;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_misaligned;
    logic [63:0] resp_rdata;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = '0;

    always #5 clk = ~clk;

    load_store_unit #(.WIDTH(64), .MEM_DWORDS(1024)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_ctrl        (req_ctrl),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder: acks after wait_states waiting cycles, logs each completed transaction.
    logic [63:0] mem [16];
    int          wait_states = 0;
    int          wcnt = 0;
    int          unstable = 0;
    logic [63:0] hold_addr, hold_wdata;
    logic [7:0]  hold_wstrb;
    logic [63:0] tx_addr[$];
    logic [63:0] tx_wdata[$];
    logic [7:0]  tx_wstrb[$];
    logic        tx_we[$];

    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (mem_req) begin
            if (wcnt == 0) begin
                hold_addr  = mem_addr;
                hold_wdata = mem_wdata;
                hold_wstrb = mem_wstrb;
            end else if (mem_addr !== hold_addr || mem_wdata !== hold_wdata ||
                         mem_wstrb !== hold_wstrb) begin
                unstable++;
            end
            if (wcnt >= wait_states) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr[6:3]];
                if (mem_we) begin
                    for (int i = 0; i < 8; i++) begin
                        if (mem_wstrb[i]) mem[mem_addr[6:3]][8*i +: 8] = mem_wdata[8*i +: 8];
                    end
                end
                tx_addr.push_back(mem_addr);
                tx_wdata.push_back(mem_wdata);
                tx_wstrb.push_back(mem_wstrb);
                tx_we.push_back(mem_we);
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Cycle 0 is the request cycle; lat counts cycles until resp_valid is seen.
    task automatic do_req(input logic wr, input logic [2:0] ctrl, input logic [63:0] addr,
                          input logic [63:0] wdata, output logic [63:0] rdata,
                          output logic mis, output int lat);
        tx_addr.delete();
        tx_wdata.delete();
        tx_wstrb.delete();
        tx_we.delete();
        @(negedge clk);
        check_eq("req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_ctrl  = ctrl;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) check_eq("resp_timeout", 64'd0, 64'd1);
        rdata = resp_rdata;
        mis   = resp_misaligned;
    endtask

    logic [63:0] rd;
    logic        mis;
    int          lat;
    int          seen;
    logic [63:0] rst_addr;
    logic [2:0]  rst_ctrl;

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_ctrl  = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 64'(req_ready), 64'd1);
        check_eq("rst_mem_req", 64'(mem_req), 64'd0);
        check_eq("rst_mem_we", 64'(mem_we), 64'd0);
        check_eq("rst_mem_addr", mem_addr, 64'd0);
        check_eq("rst_mem_wdata", mem_wdata, 64'd0);
        check_eq("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
        check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_resp_rdata", resp_rdata, 64'd0);
        rst_n = 1'b1;

        // Aligned dword store
        do_req(1'b1, MEM_DWORD, 64'h10, 64'h1122_3344_5566_7788, rd, mis, lat);
        check_eq("sd_lat", 64'(lat), 64'd2);
        check_eq("sd_ntx", 64'(tx_addr.size()), 64'd1);
        check_eq("sd_addr", tx_addr[0], 64'h10);
        check_eq("sd_we", 64'(tx_we[0]), 64'd1);
        check_eq("sd_wstrb", 64'(tx_wstrb[0]), 64'hff);
        check_eq("sd_wdata", tx_wdata[0], 64'h1122_3344_5566_7788);
        check_eq("sd_rdata", rd, 64'd0);
        check_eq("sd_mem", mem[2], 64'h1122_3344_5566_7788);
        @(negedge clk);
        check_eq("sd_pulse", 64'(resp_valid), 64'd0);

        // Signed / unsigned byte load from lane 3
        mem[1] = 64'h0000_0000_8000_0000;
        do_req(1'b0, MEM_BYTE, 64'h0b, 64'h0, rd, mis, lat);
        check_eq("lb_addr", tx_addr[0], 64'h08);
        check_eq("lb_wstrb", 64'(tx_wstrb[0]), 64'h00);
        check_eq("lb_rdata", rd, 64'hffff_ffff_ffff_ff80);
        do_req(1'b0, MEM_BYTE_U, 64'h0b, 64'h0, rd, mis, lat);
        check_eq("lbu_rdata", rd, 64'h80);
        check_eq("lbu_lat", 64'(lat), 64'd2);

        // Invalid control code: no memory access
        do_req(1'b0, MEM_INVALID, 64'h08, 64'h0, rd, mis, lat);
        check_eq("inv_lat", 64'(lat), 64'd1);
        check_eq("inv_ntx", 64'(tx_addr.size()), 64'd0);
        check_eq("inv_rdata", rd, 64'd0);
        check_eq("inv_mis", 64'(mis), 64'd0);

`ifdef LSU_MISALIGN_TRAP_EN
        do_req(1'b0, MEM_WORD, 64'h02, 64'h0, rd, mis, lat);
        check_eq("trap_lat", 64'(lat), 64'd1);
        check_eq("trap_mis", 64'(mis), 64'd1);
        check_eq("trap_ntx", 64'(tx_addr.size()), 64'd0);
        check_eq("trap_rdata", rd, 64'd0);
        rst_addr = 64'h10;
        rst_ctrl = MEM_DWORD;
        wait_states = 8;
`else
        // Split word store across 0x00/0x08
        mem[0] = '0;
        mem[1] = '0;
        do_req(1'b1, MEM_WORD, 64'h06, 64'hAABB_CCDD, rd, mis, lat);
        check_eq("sw_lat", 64'(lat), 64'd3);
        check_eq("sw_ntx", 64'(tx_addr.size()), 64'd2);
        check_eq("sw_lo_addr", tx_addr[0], 64'h00);
        check_eq("sw_lo_wstrb", 64'(tx_wstrb[0]), 64'hc0);
        check_eq("sw_lo_wdata", tx_wdata[0], 64'hccdd_0000_0000_0000);
        check_eq("sw_hi_addr", tx_addr[1], 64'h08);
        check_eq("sw_hi_wstrb", 64'(tx_wstrb[1]), 64'h03);
        check_eq("sw_hi_wdata", tx_wdata[1], 64'h0000_0000_0000_aabb);
        do_req(1'b0, MEM_WORD_U, 64'h06, 64'h0, rd, mis, lat);
        check_eq("lwu_split", rd, 64'haabb_ccdd);
        do_req(1'b0, MEM_WORD, 64'h06, 64'h0, rd, mis, lat);
        check_eq("lw_split", rd, 64'hffff_ffff_aabb_ccdd);

        // Split halfword load with 3 wait states per transaction
        mem[1] = 64'h3400_0000_0000_0000;
        mem[2] = 64'h0000_0000_0000_0092;
        wait_states = 3;
        unstable = 0;
        do_req(1'b0, MEM_HALFWORD, 64'h0f, 64'h0, rd, mis, lat);
        check_eq("lh_rdata", rd, 64'hffff_ffff_ffff_9234);
        check_eq("lh_lat", 64'(lat), 64'd9);
        check_eq("lh_lo_addr", tx_addr[0], 64'h08);
        check_eq("lh_hi_addr", tx_addr[1], 64'h10);
        check_eq("lh_stable", 64'(unstable), 64'd0);
        wait_states = 0;

        // Word load at 0x02 stays within one dword
        mem[0] = 64'h0011_f233_4455_6677;
        do_req(1'b0, MEM_WORD, 64'h02, 64'h0, rd, mis, lat);
        check_eq("lw2_ntx", 64'(tx_addr.size()), 64'd1);
        check_eq("lw2_addr", tx_addr[0], 64'h00);
        check_eq("lw2_rdata", rd, 64'hffff_ffff_f233_4455);
        check_eq("lw2_mis", 64'(mis), 64'd0);
        rst_addr = 64'h0f;
        rst_ctrl = MEM_HALFWORD;
        wait_states = 3;
`endif

        // Reset mid-transaction (HI for the split build)
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_ctrl  = rst_ctrl;
        req_addr  = rst_addr;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("pre_rst_busy", 64'(mem_req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_ready", 64'(req_ready), 64'd1);
        check_eq("arst_mem_req", 64'(mem_req), 64'd0);
        check_eq("arst_mem_addr", mem_addr, 64'd0);
        check_eq("arst_mem_wstrb", 64'(mem_wstrb), 64'd0);
        check_eq("arst_mem_wdata", mem_wdata, 64'd0);
        check_eq("arst_resp_valid", 64'(resp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        check_eq("arst_no_resp", 64'(seen), 64'd0);
        wait_states = 0;
        mem[2] = 64'h0123_4567_89ab_cdef;
        do_req(1'b0, MEM_DWORD, 64'h10, 64'h0, rd, mis, lat);
        check_eq("post_rst_rdata", rd, 64'h0123_4567_89ab_cdef);
        check_eq("post_rst_lat", 64'(lat), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
